afifo_rd_packer: RTL and testbench



---
 rtl/afifo_rd_packer.sv | 111 +++++++++++
 tb/tb_afifo_rd_packer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/afifo_rd_packer.sv
// Read-side FIFO packer: pops DATA_W entries from a show-ahead FIFO and packs
// RATIO of them into one wide registered valid/ready word; flush emits a partial tail.
module afifo_rd_packer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RATIO  = 4
) (
  input  logic                     rclk,
  input  logic                     rrst_n,
  input  logic [DATA_W-1:0]        fifo_rdata,
  input  logic                     fifo_rempty,
  output logic                     fifo_rinc,
  input  logic                     flush,
  output logic                     flush_busy,
  output logic [DATA_W*RATIO-1:0]  m_data,
  output logic [RATIO-1:0]         m_keep,
  output logic                     m_last,
  output logic                     m_valid,
  input  logic                     m_ready
);

  localparam int unsigned     OW        = DATA_W * RATIO;
  localparam int unsigned     CW        = $clog2(RATIO);
  localparam logic [CW-1:0]   LAST_LANE = CW'(RATIO - 1);

  logic [CW-1:0]    r_cnt;
  logic [OW-1:0]    r_acc;
  logic             r_flush_busy;
  logic [OW-1:0]    r_m_data;
  logic [RATIO-1:0] r_m_keep;
  logic             r_m_last;
  logic             r_m_valid;

  logic             w_out_free;
  logic             w_last_lane;
  logic             w_pop;
  logic [OW-1:0]    w_packed;
  logic [OW-1:0]    w_flush_data;
  logic [RATIO-1:0] w_flush_keep;

  // m_ready reaches fifo_rinc combinationally so a full word can be completed
  // in the same cycle the previous one is accepted.
  assign w_out_free  = !r_m_valid || m_ready;
  assign w_last_lane = (r_cnt == LAST_LANE);
  assign w_pop       = !fifo_rempty && !r_flush_busy && (!w_last_lane || w_out_free);

  always_comb begin
    w_packed     = r_acc;
    w_flush_data = '0;
    w_flush_keep = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (CW'(i) == r_cnt) begin
        w_packed[i*DATA_W +: DATA_W] = fifo_rdata;
      end
      if (CW'(i) < r_cnt) begin
        w_flush_data[i*DATA_W +: DATA_W] = r_acc[i*DATA_W +: DATA_W];
        w_flush_keep[i]                  = 1'b1;
      end
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_cnt        <= '0;
      r_acc        <= '0;
      r_flush_busy <= 1'b0;
      r_m_data     <= '0;
      r_m_keep     <= '0;
      r_m_last     <= 1'b0;
      r_m_valid    <= 1'b0;
    end else begin
      if (r_m_valid && m_ready) begin
        r_m_valid <= 1'b0;
      end
      if (w_pop) begin
        if (w_last_lane) begin
          r_m_data  <= w_packed;
          r_m_keep  <= '1;
          r_m_last  <= 1'b0;
          r_m_valid <= 1'b1;
          r_acc     <= '0;
          r_cnt     <= '0;
        end else begin
          r_acc <= w_packed;
          r_cnt <= r_cnt + 1'b1;
        end
      end
      // Pops are blocked while busy, so the flush emission never races a full word.
      if (flush && !r_flush_busy) begin
        r_flush_busy <= 1'b1;
      end else if (r_flush_busy && w_out_free) begin
        r_flush_busy <= 1'b0;
        if (r_cnt != '0) begin
          r_m_data  <= w_flush_data;
          r_m_keep  <= w_flush_keep;
          r_m_last  <= 1'b1;
          r_m_valid <= 1'b1;
          r_acc     <= '0;
          r_cnt     <= '0;
        end
      end
    end
  end

  assign fifo_rinc  = w_pop;
  assign flush_busy = r_flush_busy;
  assign m_data     = r_m_data;
  assign m_keep     = r_m_keep;
  assign m_last     = r_m_last;
  assign m_valid    = r_m_valid;

endmodule

// File: tb/tb_afifo_rd_packer.sv
// Bench for afifo_rd_packer: queue-based FIFO source, per-cycle reference model
// built from the packing rules, directed scenarios plus randomized traffic.
module tb_afifo_rd_packer;

  localparam int unsigned DW = 8;
  localparam int unsigned R  = 4;
  localparam int unsigned OW = DW * R;

  logic            rclk = 1'b0;
  logic            rrst_n;
  logic [DW-1:0]   fifo_rdata;
  logic            fifo_rempty;
  logic            fifo_rinc;
  logic            flush;
  logic            flush_busy;
  logic [OW-1:0]   m_data;
  logic [R-1:0]    m_keep;
  logic            m_last;
  logic            m_valid;
  logic            m_ready;

  afifo_rd_packer #(.DATA_W(DW), .RATIO(R)) dut (
    .rclk(rclk), .rrst_n(rrst_n),
    .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty), .fifo_rinc(fifo_rinc),
    .flush(flush), .flush_busy(flush_busy),
    .m_data(m_data), .m_keep(m_keep), .m_last(m_last),
    .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 rclk = ~rclk;

  int n_checks = 0;
  int n_fail   = 0;
  int pops     = 0;

  logic [DW-1:0] fq[$];     // FIFO contents, head at index 0
  logic [DW-1:0] pend[$];   // model: entries popped but not yet emitted
  logic          mv, ml, mb;
  logic [OW-1:0] md;
  logic [R-1:0]  mk;

  logic [OW-1:0] gd[$];     // words accepted downstream
  logic [R-1:0]  gk[$];
  logic          gl[$];

  function automatic logic [OW-1:0] pack_pend();
    logic [OW-1:0] w;
    w = '0;
    for (int i = 0; i < pend.size(); i++) w[i*DW +: DW] = pend[i];
    return w;
  endfunction

  task automatic model_reset();
    pend.delete();
    mv = 1'b0; ml = 1'b0; mb = 1'b0; md = '0; mk = '0;
  endtask

  task automatic drive_fifo();
    fifo_rempty = (fq.size() == 0);
    fifo_rdata  = (fq.size() == 0) ? '0 : fq[0];
  endtask

  task automatic push(input logic [DW-1:0] v);
    fq.push_back(v);
    drive_fifo();
  endtask

  task automatic clear_log();
    gd.delete(); gk.delete(); gl.delete();
  endtask

  // One clock cycle: sample at negedge, compare with model, advance model,
  // then let the FIFO react after the rising edge.
  task automatic tick();
    logic e_pop, free, s_rinc;
    @(negedge rclk);
    free   = !mv || m_ready;
    e_pop  = (fq.size() != 0) && !mb && ((pend.size() != R - 1) || free);
    s_rinc = fifo_rinc;
    n_checks++;
    if (fifo_rinc !== e_pop) begin
      n_fail++;
      $display("FAIL rinc t=%0t got %b expected %b", $time, fifo_rinc, e_pop);
    end
    n_checks++;
    if ({m_valid, m_last, flush_busy} !== {mv, ml, mb}) begin
      n_fail++;
      $display("FAIL ctrl t=%0t valid/last/busy got %b%b%b expected %b%b%b",
               $time, m_valid, m_last, flush_busy, mv, ml, mb);
    end
    n_checks++;
    if (m_data !== md || m_keep !== mk) begin
      n_fail++;
      $display("FAIL word t=%0t data/keep got %h/%b expected %h/%b",
               $time, m_data, m_keep, md, mk);
    end
    if (m_valid && m_ready) begin
      gd.push_back(m_data); gk.push_back(m_keep); gl.push_back(m_last);
    end
    if (mv && m_ready) mv = 1'b0;
    if (e_pop) begin
      pend.push_back(fq[0]);
      if (pend.size() == R) begin
        md = pack_pend(); mk = '1; ml = 1'b0; mv = 1'b1;
        pend.delete();
      end
    end
    if (flush && !mb) begin
      mb = 1'b1;
    end else if (mb && free) begin
      mb = 1'b0;
      if (pend.size() > 0) begin
        md = pack_pend(); mk = R'((1 << pend.size()) - 1); ml = 1'b1; mv = 1'b1;
        pend.delete();
      end
    end
    @(posedge rclk);
    #1;
    if (s_rinc && fq.size() > 0) begin
      void'(fq.pop_front());
      pops++;
    end
    flush = 1'b0;
    drive_fifo();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    fq.delete(); drive_fifo();
    flush = 1'b0; m_ready = 1'b0;
    rrst_n = 1'b1;
    #2 rrst_n = 1'b0;
    #1;
    n_checks++;
    if ({m_valid, m_last, flush_busy, fifo_rinc} !== 4'b0 || m_data !== '0 || m_keep !== '0) begin
      n_fail++;
      $display("FAIL reset_state got v%b l%b b%b r%b d%h k%b required all zero",
               m_valid, m_last, flush_busy, fifo_rinc, m_data, m_keep);
    end
    model_reset();
    @(posedge rclk); #1;
    rrst_n = 1'b1;
    ticks(2);
  endtask

  task automatic test_stream();
    clear_log(); pops = 0; m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(8'(i * 8'h11));
    ticks(8);
    n_checks++;
    if (pops != 8) begin
      n_fail++; $display("FAIL stream_pops got %0d required 8", pops);
    end
    ticks(4);
    n_checks++;
    if (gd.size() != 2 || gd[0] !== 32'h44332211 || gd[1] !== 32'h88776655 ||
        gk[0] !== 4'hF || gk[1] !== 4'hF || gl[0] !== 1'b0 || gl[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_words got %0d words first %h required 44332211,88776655 keep F",
               gd.size(), (gd.size() > 0) ? gd[0] : '0);
    end
  endtask

  task automatic test_backpressure();
    clear_log(); pops = 0; m_ready = 1'b0;
    for (int i = 1; i <= 12; i++) push(8'(i * 8'h11));
    ticks(10);
    n_checks++;
    if (pops != 7 || m_valid !== 1'b1 || m_data !== 32'h44332211 || fifo_rinc !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_stall pops %0d valid %b data %h rinc %b required 7 1 44332211 0",
               pops, m_valid, m_data, fifo_rinc);
    end
    m_ready = 1'b1;
    tick();
    n_checks++;
    if (pops != 8 || m_valid !== 1'b1 || m_data !== 32'h88776655) begin
      n_fail++;
      $display("FAIL bp_release pops %0d valid %b data %h required 8 1 88776655",
               pops, m_valid, m_data);
    end
    ticks(6);
    n_checks++;
    if (gd.size() != 3 || gd[2] !== 32'hCCBBAA99) begin
      n_fail++;
      $display("FAIL bp_drain got %0d words required 3 ending CCBBAA99", gd.size());
    end
  endtask

  task automatic test_flush_partial();
    clear_log(); m_ready = 1'b1;
    push(8'hAA); push(8'hBB); push(8'hCC);
    ticks(4);
    flush = 1'b1;
    tick();
    n_checks++;
    if (flush_busy !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fp_busy got busy %b valid %b required 1 0", flush_busy, m_valid);
    end
    tick();
    n_checks++;
    if (flush_busy !== 1'b0 || m_valid !== 1'b1 || m_data !== 32'h00CCBBAA ||
        m_keep !== 4'b0111 || m_last !== 1'b1) begin
      n_fail++;
      $display("FAIL fp_word got b%b v%b d%h k%b l%b required 0 1 00CCBBAA 0111 1",
               flush_busy, m_valid, m_data, m_keep, m_last);
    end
    for (int i = 1; i <= 4; i++) push(8'(i));
    ticks(7);
    n_checks++;
    if (gd.size() != 2 || gd[1] !== 32'h04030201 || gk[1] !== 4'hF) begin
      n_fail++;
      $display("FAIL fp_after got %0d words required 2 ending 04030201", gd.size());
    end
  endtask

  task automatic test_flush_empty();
    int nl;
    clear_log(); m_ready = 1'b1;
    flush = 1'b1;
    tick();
    n_checks++;
    if (flush_busy !== 1'b1) begin
      n_fail++; $display("FAIL fe_busy got %b required 1", flush_busy);
    end
    tick();
    n_checks++;
    if (flush_busy !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fe_idle got busy %b valid %b required 0 0", flush_busy, m_valid);
    end
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'(8'h20 + i));
    ticks(8);
    for (int i = 0; i < 4; i++) begin
      flush = 1'b1;
      tick();
    end
    n_checks++;
    if (flush_busy !== 1'b1 || fifo_rinc !== 1'b0) begin
      n_fail++;
      $display("FAIL fe_stall got busy %b rinc %b required 1 0", flush_busy, fifo_rinc);
    end
    m_ready = 1'b1;
    ticks(5);
    nl = 0;
    foreach (gl[i]) if (gl[i]) nl++;
    n_checks++;
    if (gd.size() != 2 || nl != 1 || gd[1] !== 32'h00002524 || gk[1] !== 4'b0011) begin
      n_fail++;
      $display("FAIL fe_single got %0d words %0d last required 2 words 1 last tail 00002524",
               gd.size(), nl);
    end
  endtask

  task automatic test_flush_same_cycle();
    clear_log(); m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(8'(8'h30 + i));
    ticks(3);
    flush = 1'b1;
    tick();
    n_checks++;
    if (m_valid !== 1'b1 || m_keep !== 4'hF || m_last !== 1'b0 ||
        m_data !== 32'h33323130 || flush_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL fs_word got v%b k%b l%b d%h b%b required 1 F 0 33323130 1",
               m_valid, m_keep, m_last, m_data, flush_busy);
    end
    ticks(4);
    n_checks++;
    if (gd.size() != 1 || gl[0] !== 1'b0 || flush_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fs_single got %0d words busy %b required 1 word busy 0",
               gd.size(), flush_busy);
    end
  endtask

  task automatic test_reset_mid();
    clear_log(); m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'(8'h40 + i));
    ticks(8);
    n_checks++;
    if (m_valid !== 1'b1) begin
      n_fail++; $display("FAIL rm_pre got valid %b required 1", m_valid);
    end
    rrst_n = 1'b0;
    #1;
    n_checks++;
    if ({m_valid, m_last, flush_busy} !== 3'b0 || m_data !== '0 || m_keep !== '0) begin
      n_fail++;
      $display("FAIL rm_async got v%b l%b b%b d%h k%b required all zero",
               m_valid, m_last, flush_busy, m_data, m_keep);
    end
    model_reset();
    @(posedge rclk); #1;
    rrst_n = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(8'(8'h5A + i));
    ticks(6);
    n_checks++;
    if (gd.size() != 1 || gd[0] !== 32'h5D5C5B5A || gk[0] !== 4'hF) begin
      n_fail++;
      $display("FAIL rm_clean got %0d words first %h required 1 word 5D5C5B5A",
               gd.size(), (gd.size() > 0) ? gd[0] : '0);
    end
  endtask

  task automatic test_random();
    int accepted;
    clear_log(); pops = 0; accepted = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 60) push(8'($urandom));
      m_ready = ($urandom_range(0, 99) < 70);
      flush   = ($urandom_range(0, 99) < 4);
      tick();
    end
    m_ready = 1'b1;
    flush   = 1'b1;
    tick();
    ticks(60);
    foreach (gk[i]) accepted += $countones(gk[i]);
    n_checks++;
    if (accepted != pops || fq.size() != 0) begin
      n_fail++;
      $display("FAIL rand_conservation got %0d lanes out for %0d pops (%0d left) required equal, 0 left",
               accepted, pops, fq.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_partial();
    test_flush_empty();
    test_flush_same_cycle();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
